// File: rtl/case_2_mul_arb_pkg.sv
// Shared constants, width helpers and the operand-stage payload for case_2_mul_arb.
// No logic of its own; latency and backpressure are defined by the users of this package.
// Saturation bounds are constant functions so they fold at elaboration.
package case_2_mul_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DIN0_WIDTH = 5;
    localparam int DEF_DIN1_WIDTH = 5;
    localparam int DEF_DOUT_WIDTH = 5;

    // Requester index width; a 2-requester arbiter still needs one id bit.
    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

    // Operand-stage payload at the default widths.
    typedef struct packed {
        logic [DEF_DIN0_WIDTH-1:0]      din0;
        logic [DEF_DIN1_WIDTH-1:0]      din1;
        logic [idw(DEF_NUM_REQ)-1:0]    id;
    } s1_payload_t;

endpackage

// File: rtl/case_2_mul_arb_rr.sv
// Round-robin picker: first asserted req at or above ptr, wrapping, as one-hot and index.
// Latency: purely combinational.
// Backpressure: none here; the caller qualifies the grant with its own load condition.
module case_2_mul_arb_rr
    import case_2_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = idw(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx
);

    int   scan;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        scan    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[scan]) begin
                found     = 1'b1;
                gnt[scan] = 1'b1;
                gnt_idx   = IDW'(scan);
            end
        end
    end

endmodule

// File: rtl/case_2_mul_arb.sv
// Shares one signed multiplier among NUM_REQ requesters; result tagged with requester id.
// Latency: request granted in cycle n returns rsp_valid in cycle n+2; one result per cycle.
// Backpressure: rsp_ready low stalls S2 then S1 (two in flight), then all req_ready drop. CASE_2_MUL_ARB_SAT_EN selects saturating rsp_dout.
module case_2_mul_arb
    import case_2_mul_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
    parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]  req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]  req_din1,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic signed [DOUT_WIDTH-1:0]   rsp_dout,
    output logic [idw(NUM_REQ)-1:0]        rsp_id,
    output logic                           rsp_ovf
);

    localparam int IDW = idw(NUM_REQ);
    localparam int PW  = DIN0_WIDTH + DIN1_WIDTH;

    typedef struct packed {
        logic [DIN0_WIDTH-1:0] din0;
        logic [DIN1_WIDTH-1:0] din1;
        logic [IDW-1:0]        id;
    } s1_dat_t;

    logic                         s1_vld;
    s1_dat_t                      s1_dat;
    s1_dat_t                      s1_nxt;
    logic                         s1_load;
    logic                         s2_load;
    logic                         xfer;
    logic [IDW-1:0]               ptr;
    logic [NUM_REQ-1:0]           gnt;
    logic [IDW-1:0]               gnt_idx;
    logic signed [DIN0_WIDTH-1:0] op0;
    logic signed [DIN1_WIDTH-1:0] op1;
    logic signed [PW-1:0]         prod;
    logic [PW-DOUT_WIDTH:0]       prod_hi;
    logic                         prod_ovf;
    logic [DOUT_WIDTH-1:0]        dout_nxt;

    assign s2_load = s1_vld && (!rsp_valid || rsp_ready);
    assign s1_load = !s1_vld || s2_load;

    case_2_mul_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Gated by reset so nothing is offered while the pipeline is being cleared.
    assign req_ready = (ap_rst_n && s1_load) ? gnt : '0;
    assign xfer      = |req_ready;

    always_comb begin
        s1_nxt      = '0;
        s1_nxt.din0 = req_din0[int'(gnt_idx)*DIN0_WIDTH +: DIN0_WIDTH];
        s1_nxt.din1 = req_din1[int'(gnt_idx)*DIN1_WIDTH +: DIN1_WIDTH];
        s1_nxt.id   = gnt_idx;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            ptr    <= '0;
        end else begin
            if (s1_load) begin
                s1_vld <= xfer;
            end
            if (xfer) begin
                s1_dat <= s1_nxt;
                ptr    <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
            end
        end
    end

    assign op0  = s1_dat.din0;
    assign op1  = s1_dat.din1;
    assign prod = PW'(op0) * PW'(op1);

    // Representable iff every bit from the result sign bit upward matches.
    assign prod_hi  = prod[PW-1:DOUT_WIDTH-1];
    assign prod_ovf = !((&prod_hi) || (~|prod_hi));

    always_comb begin
        dout_nxt = prod[DOUT_WIDTH-1:0];
`ifdef CASE_2_MUL_ARB_SAT_EN
        if (prod_ovf) begin
            dout_nxt = prod[PW-1] ? DOUT_WIDTH'(sat_min(DOUT_WIDTH))
                                  : DOUT_WIDTH'(sat_max(DOUT_WIDTH));
        end
`else
        dout_nxt = prod[DOUT_WIDTH-1:0];
`endif
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rsp_valid <= 1'b0;
            rsp_dout  <= '0;
            rsp_id    <= '0;
            rsp_ovf   <= 1'b0;
        end else if (s2_load) begin
            rsp_valid <= 1'b1;
            rsp_dout  <= dout_nxt;
            rsp_id    <= s1_dat.id;
            rsp_ovf   <= prod_ovf;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_case_2_mul_arb.sv
// Directed bench for case_2_mul_arb: vector table for arithmetic, hand sequences for arbitration,
// backpressure, pointer wrap and reset; also flags requesters that drop valid before ready.
module tb_case_2_mul_arb;

    logic              ap_clk;
    logic              ap_rst_n;
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [19:0]       req_din0;
    logic [19:0]       req_din1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic signed [4:0] rsp_dout;
    logic [1:0]        rsp_id;
    logic              rsp_ovf;

    int errors = 0;
    int checks = 0;

    case_2_mul_arb #(
        .NUM_REQ    (4),
        .DIN0_WIDTH (5),
        .DIN1_WIDTH (5),
        .DOUT_WIDTH (5)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_din0  (req_din0),
        .req_din1  (req_din1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dout  (rsp_dout),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic signed [31:0] act,
                         input logic signed [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    // A requester left waiting at an edge must still be valid at the next edge.
    logic [3:0] pend;
    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && !req_valid[i]) begin
                    errors++;
                    $display("FAIL protocol: requester %0d dropped valid without ready", i);
                end
            end
            pend <= req_valid & ~req_ready;
        end
    end

    typedef struct {
        int id;
        int din0;
        int din1;
        int exp_wrap;
        int exp_sat;
        int exp_ovf;
    } vec_t;

    vec_t vecs[12];
    int   rr_exp[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int   sb[$];
    int   g;
    int   grants;
    int   want_dout;

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst_n  = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    // Requester i multiplies (i+1) by -3.
    task automatic set_ops();
        for (int i = 0; i < 4; i++) begin
            req_din0[i*5 +: 5] = 5'(i + 1);
            req_din1[i*5 +: 5] = 5'(-3);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge ap_clk);
        req_din0 = '0;
        req_din1 = '0;
        req_din0[v.id*5 +: 5] = 5'(v.din0);
        req_din1[v.id*5 +: 5] = 5'(v.din1);
        req_valid = 4'(1 << v.id);
        rsp_ready = 1'b1;
        #1;
        check("vec_gnt", req_ready, 1 << v.id);
        @(negedge ap_clk);
        req_valid = '0;
        check("vec_lat_early", rsp_valid, 0);
        @(negedge ap_clk);
`ifdef CASE_2_MUL_ARB_SAT_EN
        want_dout = v.exp_sat;
`else
        want_dout = v.exp_wrap;
`endif
        check("vec_rsp_vld", rsp_valid, 1);
        check("vec_rsp_dout", rsp_dout, want_dout);
        check("vec_rsp_id", rsp_id, v.id);
        check("vec_rsp_ovf", rsp_ovf, v.exp_ovf);
        @(negedge ap_clk);
        check("vec_rsp_drained", rsp_valid, 0);
    endtask

    initial begin
        vecs[0]  = '{2,   3,  -4, -12, -12, 0};
        vecs[1]  = '{0,   7,   3, -11,  15, 1};
        vecs[2]  = '{1, -16, -16,   0,  15, 1};
        vecs[3]  = '{3, -16,   1, -16, -16, 0};
        vecs[4]  = '{2,   5,  -4,  12, -16, 1};
        vecs[5]  = '{1,  15,  15,   1,  15, 1};
        vecs[6]  = '{0,  -1,  -1,   1,   1, 0};
        vecs[7]  = '{3,   0, -16,   0,   0, 0};
        vecs[8]  = '{2,   3,   5,  15,  15, 0};
        vecs[9]  = '{1,   4,   4, -16,  15, 1};
        vecs[10] = '{0,  -4,   4, -16, -16, 0};
        vecs[11] = '{3, -16,  15, -16, -16, 1};

        // Reset values, with every requester asserting valid during reset.
        ap_rst_n  = 1'b0;
        req_valid = 4'hf;
        rsp_ready = 1'b0;
        req_din0  = '0;
        req_din1  = '0;
        repeat (2) @(negedge ap_clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_dout", rsp_dout, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_ovf", rsp_ovf, 0);
        req_valid = '0;
        ap_rst_n  = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // All requesters continuously valid, no backpressure.
        do_reset();
        set_ops();
        req_valid = 4'hf;
        rsp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (c >= 2) begin
                g = sb.pop_front();
                check("rr_rsp_vld", rsp_valid, 1);
                check("rr_rsp_id", rsp_id, g);
                check("rr_rsp_dout", rsp_dout, -3 * (g + 1));
            end
            check("rr_gnt", req_ready, 1 << rr_exp[c]);
            sb.push_back(rr_exp[c]);
            @(negedge ap_clk);
        end

        // Backpressure: two accepted, then stalled and stable.
        do_reset();
        set_ops();
        req_valid = 4'hf;
        rsp_ready = 1'b0;
        grants    = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (req_ready != 0) grants++;
            if (c == 0) check("bp_gnt0", req_ready, 1);
            if (c == 1) begin
                check("bp_gnt1", req_ready, 2);
                check("bp_rsp_early", rsp_valid, 0);
            end
            if (c >= 2) begin
                check("bp_stall_rdy", req_ready, 0);
                check("bp_hold_vld", rsp_valid, 1);
                check("bp_hold_id", rsp_id, 0);
                check("bp_hold_dout", rsp_dout, -3);
            end
            @(negedge ap_clk);
        end
        check("bp_grants", grants, 2);
        rsp_ready = 1'b1;
        #1;
        check("bp_resume_gnt", req_ready, 4);
        check("bp_drain0_id", rsp_id, 0);
        @(negedge ap_clk);
        #1;
        check("bp_drain1_id", rsp_id, 1);
        check("bp_drain1_dout", rsp_dout, -6);
        check("bp_next_gnt", req_ready, 8);
        @(negedge ap_clk);
        #1;
        check("bp_drain2_id", rsp_id, 2);
        check("bp_drain2_dout", rsp_dout, -9);
        @(negedge ap_clk);
        #1;
        check("bp_drain3_id", rsp_id, 3);
        check("bp_drain3_dout", rsp_dout, -12);

        // Pointer at 1 with only requesters 3 and 0 valid.
        do_reset();
        set_ops();
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        check("skip_setup_gnt", req_ready, 1);
        @(negedge ap_clk);
        req_valid = 4'b0000;
        @(negedge ap_clk);
        req_valid = 4'b1001;
        #1;
        check("skip_gnt3", req_ready, 8);
        @(negedge ap_clk);
        req_valid = 4'b0001;
        #1;
        check("skip_gnt0", req_ready, 1);
        @(negedge ap_clk);
        req_valid = 4'b0000;
        #1;
        check("skip_rsp3_id", rsp_id, 3);
        check("skip_rsp3_dout", rsp_dout, -12);
        @(negedge ap_clk);
        #1;
        check("skip_rsp0_id", rsp_id, 0);
        check("skip_rsp0_vld", rsp_valid, 1);

        // Reset with two transactions in flight.
        do_reset();
        set_ops();
        req_valid = 4'hf;
        rsp_ready = 1'b0;
        repeat (2) @(negedge ap_clk);
        #1;
        check("mid_pre_vld", rsp_valid, 1);
        ap_rst_n  = 1'b0;
        req_valid = 4'b0110;
        #1;
        check("mid_rst_vld", rsp_valid, 0);
        check("mid_rst_rdy", req_ready, 0);
        @(negedge ap_clk);
        ap_rst_n  = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("mid_first_gnt", req_ready, 2);
        @(negedge ap_clk);
        req_valid = 4'b0100;
        #1;
        check("mid_no_stale", rsp_valid, 0);
        check("mid_second_gnt", req_ready, 4);
        @(negedge ap_clk);
        req_valid = 4'b0000;
        #1;
        check("mid_rsp1_vld", rsp_valid, 1);
        check("mid_rsp1_id", rsp_id, 1);
        check("mid_rsp1_dout", rsp_dout, -6);
        @(negedge ap_clk);
        #1;
        check("mid_rsp2_id", rsp_id, 2);
        check("mid_rsp2_dout", rsp_dout, -9);
        @(negedge ap_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/case_2_mul_arb.md
# case_2_mul_arb

Round-robin arbiter and 2-stage issue pipeline that shares one signed multiplier among NUM_REQ requesters. Each requester presents a pair of signed operands with a valid/ready handshake. The block grants one requester per cycle, registers the operands, forms the signed product, and returns the result tagged with the requester index on a single valid/ready response channel. It sits between the scheduled operation units of the case_2 datapath and the shared multiplier resource.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DIN0_WIDTH, 5, signed operand 0 width
- DIN1_WIDTH, 5, signed operand 1 width
- DOUT_WIDTH, 5, result width (≤ DIN0_WIDTH+DIN1_WIDTH)
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant; at most one bit high per cycle
- req_din0  in  NUM_REQ*DIN0_WIDTH  packed operand 0; slice i belongs to requester i
- req_din1  in  NUM_REQ*DIN1_WIDTH  packed operand 1
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_dout  out  DOUT_WIDTH  signed result
- rsp_id  out  IDW = max(1, clog2(NUM_REQ))  index of the originating requester
- rsp_ovf  out  1  full product not representable in DOUT_WIDTH signed

## Operation
- Handshake: a transfer occurs when valid && ready. A requester holds valid and its operands stable until ready. Ready never depends on the requester's own operand values.
- Pipeline: S1 holds the operand register (din0, din1, id, s1_v). S2 holds the result register (dout, id, ovf, rsp_valid).
- Load conditions:
  - s2_load = s1_v && (!rsp_valid || rsp_ready)
  - s1_load = !s1_v || s2_load
- Grant: when s1_load is true, req_ready[g] = 1 for g = the first i with req_valid[i], scanning from ptr upward with wrap. All other ready bits are 0. If no requester is valid, no grant is made.
- Pointer: ptr resets to 0. On a transfer from requester g, ptr ← (g+1) mod NUM_REQ. Without a transfer, ptr is unchanged.
- Arithmetic:
  - Full product P = $signed(din0) * $signed(din1), width DIN0_WIDTH+DIN1_WIDTH.
  - rsp_ovf = 1 when P < −2^(DOUT_WIDTH−1) or P > 2^(DOUT_WIDTH−1)−1.
  - rsp_dout depends on the configuration (see below).
- Ordering: responses return in grant order. There is no reordering and no dropping.
- Simultaneous events:
  - rsp_ready together with a new grant: S2 takes S1 and S1 takes the new request in the same edge.
  - A requester deasserting valid without ready is a protocol violation. The bench asserts on it.

## Timing
- Latency: a request accepted at edge n produces rsp_valid at edge n+2 when there is no backpressure.
- Throughput: 1 result per cycle with rsp_ready held high.
- Backpressure: with rsp_ready low, at most 2 transactions are in flight (S1 + S2). After that all req_ready bits stay 0.
- Reset values: s1_v=0, rsp_valid=0, rsp_dout=0, rsp_id=0, rsp_ovf=0, ptr=0. req_ready=0 while ap_rst_n is low.
- Reset mid-operation: in-flight transactions are discarded with no response. Arbitration restarts at requester 0 on the first edge after release.
- Outputs S2 are registered. req_ready is combinational from req_valid, ptr, s1_v, rsp_valid and rsp_ready.

## Configuration
- CASE_2_MUL_ARB_SAT_EN defined: rsp_dout saturates. It is 2^(DOUT_WIDTH−1)−1 on positive overflow, −2^(DOUT_WIDTH−1) on negative overflow, and P otherwise.
- Not defined: rsp_dout = P[DOUT_WIDTH−1:0] (two's-complement wrap).
- rsp_ovf is computed identically in both modes.

## Structure
- Package case_2_mul_arb_pkg contains:
  - default width constants
  - IDW function
  - saturation max/min constant functions
  - the S1 payload struct (din0, din1, id)
- Sub-module case_2_mul_arb_rr holds the round-robin picker. Inputs: req vector and ptr. Outputs: one-hot grant and grant index; it is purely combinational. The ptr register stays in the top module.

## Test plan
- Single request: req 2 with din0=3, din1=−4, no backpressure → rsp_valid two cycles later with rsp_dout=−12, rsp_id=2, rsp_ovf=0.
- All four requesters valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0; one rsp per cycle with matching ids.
- Overflow: 7×3 → rsp_ovf=1, rsp_dout=−11 (wrap) or 15 (SAT_EN). −16×−16 → rsp_ovf=1, rsp_dout=0 (wrap) or 15 (SAT_EN). −16×1 → rsp_ovf=0, rsp_dout=−16.
- Backpressure: rsp_ready low 5 cycles with all valid → exactly 2 grants, then all req_ready=0. rsp holds stable. On rsp_ready=1, results drain in order and granting resumes at ptr.
- Pointer skip: ptr=1, only req 3 and req 0 valid → grant 3, then grant 0.
- Reset mid-operation: assert ap_rst_n low with 2 in flight → rsp_valid=0 immediately. After release, first grant goes to the lowest valid index and no stale result appears.
